// File: rtl/dmem_arbiter.sv
`default_nettype none
`ifndef WORD
`define WORD 64
`endif
// ----------------------------------------------------------------------------------------------
// dmem_arbiter: two-port (CPU / debug-loader) arbiter in front of data_mem, one access per 3 cycles.
// DMEM_ARB_RR_EN selects round-robin tie-break; otherwise port 0 has fixed priority.  Rev 1.0
// ----------------------------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int WIDTH = `WORD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p0_req,
  input  logic             p0_we,
  input  logic [WIDTH-1:0] p0_addr,
  input  logic [WIDTH-1:0] p0_wdata,
  output logic             p0_ack,
  output logic [WIDTH-1:0] p0_rdata,
  input  logic             p1_req,
  input  logic             p1_we,
  input  logic [WIDTH-1:0] p1_addr,
  input  logic [WIDTH-1:0] p1_wdata,
  output logic             p1_ack,
  output logic [WIDTH-1:0] p1_rdata,
  output logic             mem_MemRead,
  output logic             mem_MemWrite,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_w_data,
  input  logic [WIDTH-1:0] mem_r_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t             state_q;
  logic               gnt_q;
  logic               gnt_d;
  logic               p0_ack_q;
  logic               p1_ack_q;
  logic [WIDTH-1:0]   p0_rdata_q;
  logic [WIDTH-1:0]   p1_rdata_q;
  logic               mem_re_q;
  logic               mem_we_q;
  logic [WIDTH-1:0]   mem_addr_q;
  logic [WIDTH-1:0]   mem_wdata_q;
  logic               busy_q;

`ifdef DMEM_ARB_RR_EN
  logic               last_q;

  // On a tie the port that was not served last wins.
  always_comb begin
    if (p0_req && p1_req) gnt_d = ~last_q;
    else                  gnt_d = ~p0_req;
  end
`else
  always_comb gnt_d = ~p0_req;
`endif

  // The mem-side registers double as the latched request fields, so inputs may
  // change freely once the grant edge has passed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= 1'b0;
      p0_ack_q    <= 1'b0;
      p1_ack_q    <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      last_q      <= 1'b1;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (p0_req || p1_req) begin
            gnt_q       <= gnt_d;
            mem_addr_q  <= gnt_d ? p1_addr  : p0_addr;
            mem_wdata_q <= gnt_d ? p1_wdata : p0_wdata;
            mem_we_q    <= gnt_d ? p1_we    : p0_we;
            mem_re_q    <= gnt_d ? ~p1_we   : ~p0_we;
            busy_q      <= 1'b1;
            state_q     <= S_ACCESS;
`ifdef DMEM_ARB_RR_EN
            last_q      <= gnt_d;
`endif
          end
        end
        S_ACCESS: begin
          if (mem_re_q) begin
            if (gnt_q) p1_rdata_q <= mem_r_data;
            else       p0_rdata_q <= mem_r_data;
          end
          mem_re_q <= 1'b0;
          mem_we_q <= 1'b0;
          p0_ack_q <= ~gnt_q;
          p1_ack_q <= gnt_q;
          state_q  <= S_RESP;
        end
        S_RESP: begin
          p0_ack_q <= 1'b0;
          p1_ack_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign p0_ack       = p0_ack_q;
  assign p1_ack       = p1_ack_q;
  assign p0_rdata     = p0_rdata_q;
  assign p1_rdata     = p1_rdata_q;
  assign mem_MemRead  = mem_re_q;
  assign mem_MemWrite = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_w_data   = mem_wdata_q;
  assign busy         = busy_q;

endmodule
`default_nettype wire
